// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring divider.
// Both retire one bit per cycle on magnitudes, and signs are fixed up in one extra cycle.
// MTHI/MTLO write HI/LO directly from rs while the unit is idle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_rs,
    input  logic [WIDTH-1:0] data_rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    // Multiplicand for multiply, divisor for divide (always a magnitude)
    logic [WIDTH-1:0]   opnd_b;
    // Multiply: {partial product high, remaining multiplier bits}
    // Divide:   {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0] acc;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               op_signed;
    logic               op_arith;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] acc_next;

    // Magnitude of an operand; only signed ops fold negative values.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic sgn);
        if (sgn && x[WIDTH-1])
            return -x;
        else
            return x;
    endfunction

    // Conditionally two's-complement negate a single-width value.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    // Conditionally two's-complement negate a double-width value.
    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                     input logic neg);
        return neg ? -x : x;
    endfunction

    assign op_signed = ~op[0];
    assign op_arith  = ~op[2];

    // One iteration of the shift-add multiplier or the restoring divider.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd_b});
        // The remainder is always below the divisor after a successful subtract,
        // so the low WIDTH bits of the difference are exact.
        div_sub   = div_shift[WIDTH-1:0] - opnd_b;
        acc_next  = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_ge)
                acc_next = {div_sub, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, iteration datapath and architectural HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            opnd_b   <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (op_arith) begin
                            is_div   <= op[1];
                            neg_q    <= op_signed & (data_rs[WIDTH-1] ^ data_rt[WIDTH-1]);
                            neg_r    <= op_signed & data_rs[WIDTH-1];
                            div_zero <= op[1] & (data_rt == '0);
                            if (op[1]) begin
                                acc    <= {{WIDTH{1'b0}}, magnitude(data_rs, op_signed)};
                                opnd_b <= magnitude(data_rt, op_signed);
                            end else begin
                                acc    <= {{WIDTH{1'b0}}, magnitude(data_rt, op_signed)};
                                opnd_b <= magnitude(data_rs, op_signed);
                            end
                            count <= CW'(WIDTH - 1);
                            busy  <= 1'b1;
                            state <= CALC;
                        end else if (op == 3'b100) begin
                            hi <= data_rs;
                        end else if (op == 3'b101) begin
                            lo <= data_rs;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (count == '0)
                        state <= FIX;
                    else
                        count <= count - CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        hi <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
                        lo <= div_zero ? '1 : cond_neg(acc[WIDTH-1:0], neg_q);
                    end else begin
                        {hi, lo} <= cond_neg2(acc, neg_q);
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_rs;
    logic [31:0] data_rt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] hl_exp = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data_rs (data_rs),
        .data_rt (data_rt),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference {hi,lo} after an op, from the architectural definition.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; return p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            3'd4: return {a, prev[31:0]};
            3'd5: return {prev[63:32], a};
            default: return prev;
        endcase
    endfunction

    // Present one start for exactly one rising edge; returns on the falling edge after it.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; data_rs = a; data_rt = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the acceptance edge; bounded wait for done.
    task automatic wait_done(output int nbusy, output int dcyc);
        int  c;
        bit  seen;
        nbusy = 0; dcyc = -1; c = 1; seen = 0;
        while (!seen && c <= 80) begin
            if (done === 1'b1) begin
                dcyc = c;
                seen = 1;
            end else begin
                if (busy === 1'b1) nbusy++;
                @(negedge clk);
                c++;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        int nb, dc;
        hl_exp = model(o, a, b, hl_exp);
        issue(o, a, b);
        if (o < 3'd4) begin
            wait_done(nb, dc);
            chk($sformatf("%s done_cycle", tag), dc, 34);
            chk($sformatf("%s busy_cycles", tag), nb, 33);
        end
        chk($sformatf("%s hi", tag), hi, hl_exp[63:32]);
        chk($sformatf("%s lo", tag), lo, hl_exp[31:0]);
        @(negedge clk);
        chk($sformatf("%s done_low_after", tag), done, 1'b0);
        chk($sformatf("%s busy_low_after", tag), busy, 1'b0);
    endtask

    initial begin
        int          nb, dc;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 3'd0; data_rs = '0; data_rt = '0;
        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: unsigned multiply with latency
        do_op("multu_ff_2", 3'd1, 32'hFFFF_FFFF, 32'h2);
        chk("t1 hi const", hi, 32'h1);
        chk("t1 lo const", lo, 32'hFFFF_FFFE);

        // 2: signed multiplies
        do_op("mult_neg3_5", 3'd0, 32'hFFFF_FFFD, 32'h5);
        chk("t2a lo const", lo, 32'hFFFF_FFF1);
        do_op("mult_min_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
        chk("t2b hi const", hi, 32'h4000_0000);

        // 3: divides
        do_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'h2);
        chk("t3a lo const", lo, 32'hFFFF_FFFD);
        chk("t3a hi const", hi, 32'hFFFF_FFFF);
        do_op("divu_100_7", 3'd3, 32'd100, 32'd7);
        chk("t3b lo const", lo, 32'd14);
        chk("t3b hi const", hi, 32'd2);
        do_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("t3c lo const", lo, 32'h8000_0000);
        chk("t3c hi const", hi, 32'h0);

        // 4: divide by zero, both signednesses
        do_op("divu_by0", 3'd3, 32'h1234, 32'h0);
        chk("t4 lo const", lo, 32'hFFFF_FFFF);
        chk("t4 hi const", hi, 32'h1234);
        do_op("div_neg_by0", 3'd2, 32'hFFFF_FF00, 32'h0);

        // A start presented during the DONE cycle is dropped
        hl_exp = model(3'd1, 32'd2, 32'd3, hl_exp);
        issue(3'd1, 32'd2, 32'd3);
        wait_done(nb, dc);
        chk("done_state done_cycle", dc, 34);
        start = 1'b1; op = 3'd5; data_rs = 32'h99;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done lo", lo, 32'd6);
        chk("start_in_done busy", busy, 1'b0);

        // 5: starts while busy are ignored
        hl_exp = model(3'd1, 32'd3, 32'd4, hl_exp);
        issue(3'd1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        chk("t5 busy at cycle 10", busy, 1'b1);
        start = 1'b1; op = 3'd5; data_rs = 32'hAAAA;
        @(negedge clk);
        op = 3'd3; data_rs = 32'd1000; data_rt = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("t5 hold hi while busy", hi, 32'h0);
        chk("t5 hold lo while busy", lo, 32'd6);
        wait_done(nb, dc);
        chk("t5 done seen", (dc > 0), 1'b1);
        chk("t5 hi", hi, 32'h0);
        chk("t5 lo", lo, 32'd12);
        @(negedge clk);
        issue(3'd4, 32'h55, 32'h0);
        chk("t5 mthi hi", hi, 32'h55);
        chk("t5 mthi lo", lo, 32'd12);
        chk("t5 mthi done", done, 1'b0);
        chk("t5 mthi busy", busy, 1'b0);
        hl_exp = {32'h55, 32'd12};

        // 6: asynchronous reset mid-divide
        issue(3'd5, 32'h77, 32'h0);
        chk("t6 mtlo lo", lo, 32'h77);
        issue(3'd2, 32'd1000, 32'd9);
        repeat (14) @(negedge clk);
        chk("t6 busy before rst", busy, 1'b1);
        chk("t6 lo held before rst", lo, 32'h77);
        rst = 1'b1;
        #1;
        chk("t6 async busy", busy, 1'b0);
        chk("t6 async done", done, 1'b0);
        chk("t6 async hi", hi, 32'h0);
        chk("t6 async lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hl_exp = '0;
        do_op("multu_6_7", 3'd1, 32'd6, 32'd7);
        chk("t6 lo const", lo, 32'd42);

        // Randomized ops against the model
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            do_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
